// File: rtl/key_press_capture_pkg.sv
// Shared definitions for the keypad front end: FSM states and one-hot key codes.
package key_press_capture_pkg;

  localparam int unsigned KEY_W = 4;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    DEB_PRESS   = 2'd1,
    HELD        = 2'd2,
    DEB_RELEASE = 2'd3
  } state_t;

  localparam logic [KEY_W-1:0] KEY_1 = 4'h8;
  localparam logic [KEY_W-1:0] KEY_2 = 4'h4;
  localparam logic [KEY_W-1:0] KEY_3 = 4'h2;
  localparam logic [KEY_W-1:0] KEY_4 = 4'h1;

endpackage

// File: rtl/key_synchroniser.sv
// Parameterised-width 2-flop synchroniser for asynchronous inputs.
// Reset loads the caller-supplied idle level so no false edge follows reset.
module key_synchroniser #(
  parameter int unsigned W = 1
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [W-1:0] i_rst_val,
  input  logic [W-1:0] i_async,
  output logic [W-1:0] o_sync
);

  logic [W-1:0] r_meta;
  logic [W-1:0] r_sync;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_meta <= i_rst_val;
      r_sync <= i_rst_val;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;

endmodule

// File: rtl/key_press_capture.sv
// Keypad front end: synchronise, debounce and encode a single key press as a
// held one-hot code plus a one-cycle strobe; multi-key patterns raise key_error.
module key_press_capture
  import key_press_capture_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter bit          KEY_ACTIVE_LOW  = 1'b1,
  parameter int unsigned CNT_W           = 20
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [KEY_W-1:0] key_raw,
  output logic [KEY_W-1:0] key_code,
  output logic             key_valid,
  output logic             key_error,
  output logic             busy
);

  localparam logic [KEY_W-1:0] RELEASED = {KEY_W{KEY_ACTIVE_LOW}};
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  function automatic logic is_one_hot(input logic [KEY_W-1:0] v);
    return (v == KEY_1) || (v == KEY_2) || (v == KEY_3) || (v == KEY_4);
  endfunction

  logic [KEY_W-1:0] w_sync;
  logic [KEY_W-1:0] w_p;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [KEY_W-1:0] r_cand;
  logic [KEY_W-1:0] r_key_code;
  logic             r_key_valid;
  logic             r_key_error;
  logic             r_busy;

  key_synchroniser #(
    .W (KEY_W)
  ) u_sync (
    .i_clk     (clock),
    .i_rst     (reset),
    .i_rst_val (RELEASED),
    .i_async   (key_raw),
    .o_sync    (w_sync)
  );

  // XOR with the released level yields 1 = pressed for either polarity.
  assign w_p = w_sync ^ RELEASED;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_cand      <= '0;
      r_key_code  <= '0;
      r_key_valid <= 1'b0;
      r_key_error <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_key_valid <= 1'b0;
      r_key_error <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_p != '0) begin
            r_cand  <= w_p;
            r_cnt   <= '0;
            r_state <= DEB_PRESS;
            r_busy  <= 1'b1;
          end
        end
        DEB_PRESS: begin
          if (w_p != r_cand) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else if (r_cnt == CNT_LAST) begin
            if (is_one_hot(r_cand)) begin
              r_key_code  <= r_cand;
              r_key_valid <= 1'b1;
            end else begin
              r_key_error <= 1'b1;
            end
            r_state <= HELD;
          end else if (r_cnt != CNT_MAX) begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        HELD: begin
          // Pattern changes while held are ignored; only full release matters.
          if (w_p == '0) begin
            r_cnt   <= '0;
            r_state <= DEB_RELEASE;
          end
        end
        DEB_RELEASE: begin
          if (w_p != '0) begin
            r_state <= HELD;
          end else if (r_cnt == CNT_LAST) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else if (r_cnt != CNT_MAX) begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign key_code  = r_key_code;
  assign key_valid = r_key_valid;
  assign key_error = r_key_error;
  assign busy      = r_busy;

endmodule
